dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Per-requester data-memory port bundle plus the shared access-size type.
// The master modport is the requester side and the slave modport is the arbiter side.
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_t;
endpackage

interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic        req;
    logic        wr_en;
    logic        lock;
    logic        zero_extend;
    mem_size_t   size;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] rd_data;

    modport master (
        output req, wr_en, lock, zero_extend, size, addr, wr_data,
        input  gnt, rvalid, err, rd_data
    );

    modport slave (
        input  req, wr_en, lock, zero_extend, size, addr, wr_data,
        output gnt, rvalid, err, rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (m0 core, m1 DMA) data-memory arbiter with bounded locking and error checks.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        m0,
    dmem_arbiter_if.slave        m1,
    output logic                 dmem_req,
    output logic                 dmem_wr_en,
    output logic                 dmem_zero_extend,
    output mem_size_t            dmem_data_size,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wr_data,
    input  logic [31:0]          dmem_rd_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    localparam int unsigned     CntW     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_MAX - 1);
    localparam logic [32:0]     AddrLim  = 33'd1 << ADDR_WIDTH;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic            err0_q, err0_d, err1_q, err1_d;
    logic [31:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Grants are masked while reset is sampled low so nothing is consumed mid-reset.
    logic gnt0, gnt1, any_gnt;
    assign gnt0    = rst_n && (state_q == GRANT0);
    assign gnt1    = rst_n && (state_q == GRANT1);
    assign any_gnt = gnt0 | gnt1;

    logic        g_wr_en, g_zext;
    mem_size_t   g_size;
    logic [31:0] g_addr, g_wdata;
    assign g_wr_en = gnt1 ? m1.wr_en       : m0.wr_en;
    assign g_zext  = gnt1 ? m1.zero_extend : m0.zero_extend;
    assign g_size  = gnt1 ? m1.size        : m0.size;
    assign g_addr  = gnt1 ? m1.addr        : m0.addr;
    assign g_wdata = gnt1 ? m1.wr_data     : m0.wr_data;

    logic [2:0]  nbytes;
    logic        misalign, size_bad, acc_err;
    logic [32:0] last_byte;

    always_comb begin
        nbytes   = 3'd4;
        misalign = 1'b0;
        size_bad = 1'b0;
        unique case (g_size)
            MemByte: nbytes = 3'd1;
            MemHalf: begin
                nbytes   = 3'd2;
                misalign = g_addr[0];
            end
            MemWord: misalign = |g_addr[1:0];
            default: size_bad = 1'b1;
        endcase
        // 33-bit sum so an access running past the top of memory cannot wrap.
        last_byte = {1'b0, g_addr} + {30'b0, nbytes} - 33'd1;
        acc_err   = misalign | size_bad | (last_byte >= AddrLim);
    end

    assign dmem_req         = any_gnt & ~acc_err;
    assign dmem_wr_en       = dmem_req ? g_wr_en : 1'b0;
    assign dmem_zero_extend = dmem_req ? g_zext  : 1'b0;
    assign dmem_data_size   = dmem_req ? g_size  : MemByte;
    assign dmem_addr        = dmem_req ? g_addr  : 32'h0;
    assign dmem_wr_data     = dmem_req ? g_wdata : 32'h0;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;  // 1: m1 wins the next contention in IDLE
`endif

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0.req && m1.req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    state_d = rr_q ? GRANT1 : GRANT0;
`else
                    state_d = GRANT0;
`endif
                end else if (m0.req) begin
                    state_d = GRANT0;
                end else if (m1.req) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                rr_d = 1'b1;
`endif
                if (m0.req && m0.lock && (lock_cnt_q < LockLast)) begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end else if (m1.req) begin
                    state_d = GRANT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                rr_d = 1'b0;
`endif
                if (m1.req && m1.lock && (lock_cnt_q < LockLast)) begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end else if (m0.req) begin
                    state_d = GRANT0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured in the grant cycle; writes and errors complete with zero data.
    always_comb begin
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = err0_q;
        err1_d    = err1_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (gnt0) begin
            err0_d   = acc_err;
            rdata0_d = (acc_err || g_wr_en) ? 32'h0 : dmem_rd_data;
        end
        if (gnt1) begin
            err1_d   = acc_err;
            rdata1_d = (acc_err || g_wr_en) ? 32'h0 : dmem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign m0.gnt     = gnt0;
    assign m1.gnt     = gnt1;
    assign m0.rvalid  = rvalid0_q;
    assign m1.rvalid  = rvalid1_q;
    assign m0.err     = err0_q;
    assign m1.err     = err1_q;
    assign m0.rd_data = rdata0_q;
    assign m1.rd_data = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected grants and
// responses into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if m0_bus ();
    dmem_arbiter_if m1_bus ();

    logic        dmem_req, dmem_wr_en, dmem_zero_extend;
    mem_size_t   dmem_data_size;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;

    dmem_arbiter #(
        .ADDR_WIDTH (16),
        .LOCK_MAX   (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0               (m0_bus),
        .m1               (m1_bus),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_data_size   (dmem_data_size),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data)
    );

    // Little-endian byte memory; the memory itself performs sign/zero extension.
    logic [7:0]  mem [0:65535];
    logic        loaded = 1'b0;
    logic [15:0] wa;
    logic [7:0]  rd_b;
    logic [15:0] rd_h;
    assign wa = dmem_addr[15:0];

    always_comb begin
        rd_b = mem[wa];
        rd_h = {mem[wa + 16'd1], mem[wa]};
        case (dmem_data_size)
            MemByte: dmem_rd_data = dmem_zero_extend ? {24'h0, rd_b} : {{24{rd_b[7]}}, rd_b};
            MemHalf: dmem_rd_data = dmem_zero_extend ? {16'h0, rd_h} : {{16{rd_h[15]}}, rd_h};
            default: dmem_rd_data = {mem[wa + 16'd3], mem[wa + 16'd2], rd_h};
        endcase
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem[16'h0002] <= 8'h11; mem[16'h0003] <= 8'h22;
            mem[16'h0010] <= 8'hEF; mem[16'h0011] <= 8'hBE;
            mem[16'h0012] <= 8'hAD; mem[16'h0013] <= 8'hDE;
            mem[16'h0020] <= 8'h80;
            mem[16'h0030] <= 8'h34; mem[16'h0031] <= 8'hA5;
            mem[16'h0040] <= 8'h78; mem[16'h0041] <= 8'h56;
            mem[16'h0042] <= 8'h34; mem[16'h0043] <= 8'h12;
            mem[16'hFFFC] <= 8'h44; mem[16'hFFFD] <= 8'h33;
            mem[16'hFFFE] <= 8'h22; mem[16'hFFFF] <= 8'h11;
            loaded <= 1'b1;
        end else if (dmem_req && dmem_wr_en) begin
            case (dmem_data_size)
                MemByte: mem[wa] <= dmem_wr_data[7:0];
                MemHalf: begin
                    mem[wa]         <= dmem_wr_data[7:0];
                    mem[wa + 16'd1] <= dmem_wr_data[15:8];
                end
                default: begin
                    mem[wa]         <= dmem_wr_data[7:0];
                    mem[wa + 16'd1] <= dmem_wr_data[15:8];
                    mem[wa + 16'd2] <= dmem_wr_data[23:16];
                    mem[wa + 16'd3] <= dmem_wr_data[31:24];
                end
            endcase
        end
    end

    typedef struct {
        int          id;
        logic        dreq;
        logic [31:0] addr;
    } gnt_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    gnt_exp_t gq [$];
    rsp_t     rq0 [$];
    rsp_t     rq1 [$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic expect_gnt(input int m, input logic dr, input logic [31:0] a);
        gnt_exp_t e;
        e.id   = m;
        e.dreq = dr;
        e.addr = dr ? a : 32'h0;
        gq.push_back(e);
    endtask

    task automatic expect_rsp(input int m, input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        if (m == 0) rq0.push_back(r);
        else        rq1.push_back(r);
    endtask

    task automatic drive(input int m, input logic rq, input logic wr, input mem_size_t sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic ze,
                         input logic lk);
        if (m == 0) begin
            m0_bus.req = rq; m0_bus.wr_en = wr; m0_bus.size = sz; m0_bus.addr = a;
            m0_bus.wr_data = wd; m0_bus.zero_extend = ze; m0_bus.lock = lk;
        end else begin
            m1_bus.req = rq; m1_bus.wr_en = wr; m1_bus.size = sz; m1_bus.addr = a;
            m1_bus.wr_data = wd; m1_bus.zero_extend = ze; m1_bus.lock = lk;
        end
    endtask

    // Holds the request until granted; waited counts negedges up to and including the grant.
    task automatic issue(input int m, input logic wr, input mem_size_t sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic ze, input logic lk,
                         output int waited);
        logic g;
        drive(m, 1'b1, wr, sz, a, wd, ze, lk);
        waited = 0;
        g      = 1'b0;
        while (!g && waited < 50) begin
            @(negedge clk);
            waited++;
            g = (m == 0) ? m0_bus.gnt : m1_bus.gnt;
        end
        if (!g) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        drive(m, 1'b0, 1'b0, MemByte, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: grant order/dmem bus on every grant, one-cycle rvalid latency, response data.
    initial begin
        logic     exp_rv0, exp_rv1;
        gnt_exp_t g;
        rsp_t     r;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        forever begin
            @(negedge clk);
            if (m0_bus.gnt && m1_bus.gnt) check("dual_gnt", 32'd1, 32'd0);
            if (m0_bus.rvalid || exp_rv0) check("rvalid_m0", m0_bus.rvalid, exp_rv0);
            if (m1_bus.rvalid || exp_rv1) check("rvalid_m1", m1_bus.rvalid, exp_rv1);
            if (m0_bus.rvalid) begin
                if (rq0.size() == 0) check("rsp_unexpected_m0", 32'd1, 32'd0);
                else begin
                    r = rq0.pop_front();
                    check("rd_data_m0", m0_bus.rd_data, r.data);
                    check("err_m0", m0_bus.err, r.err);
                end
            end
            if (m1_bus.rvalid) begin
                if (rq1.size() == 0) check("rsp_unexpected_m1", 32'd1, 32'd0);
                else begin
                    r = rq1.pop_front();
                    check("rd_data_m1", m1_bus.rd_data, r.data);
                    check("err_m1", m1_bus.err, r.err);
                end
            end
            if (m0_bus.gnt || m1_bus.gnt) begin
                if (gq.size() == 0) check("gnt_unexpected", 32'd1, 32'd0);
                else begin
                    g = gq.pop_front();
                    check("gnt_owner", m1_bus.gnt ? 32'd1 : 32'd0, g.id);
                    check("dmem_req", dmem_req, g.dreq);
                    check("dmem_addr", dmem_addr, g.addr);
                end
            end
            exp_rv0 = m0_bus.gnt;
            exp_rv1 = m1_bus.gnt;
        end
    end

    initial begin
        int w0, w1, wa_, wb_;
        drive(0, 1'b0, 1'b0, MemByte, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, MemByte, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {m0_bus.gnt, m1_bus.gnt}, 32'd0);
        check("rst_rvalid_err", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.err, m1_bus.err}, 32'd0);
        check("rst_rd_data", m0_bus.rd_data | m1_bus.rd_data, 32'd0);
        check("rst_dmem_req", dmem_req, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid,
                                   dmem_req}, 32'd0);
        idle(1);

        // Minimum-latency word read.
        expect_gnt(0, 1'b1, 32'h10);
        expect_rsp(0, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, MemWord, 32'h10, 32'h0, 1'b0, 1'b0, w0);
        check("lat_m0_gnt", w0, 32'd2);
        idle(3);

        // Contention from IDLE, last served m0.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        expect_gnt(1, 1'b1, 32'h40);
        expect_gnt(0, 1'b1, 32'h10);
`else
        expect_gnt(0, 1'b1, 32'h10);
        expect_gnt(1, 1'b1, 32'h40);
`endif
        expect_rsp(0, 32'hDEADBEEF, 1'b0);
        expect_rsp(1, 32'h12345678, 1'b0);
        fork
            issue(0, 1'b0, MemWord, 32'h10, 32'h0, 1'b0, 1'b0, w0);
            issue(1, 1'b0, MemWord, 32'h40, 32'h0, 1'b0, 1'b0, w1);
        join
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        check("contend_lat_m1", w1, 32'd2);
        check("contend_lat_m0", w0, 32'd3);
`else
        check("contend_lat_m0", w0, 32'd2);
        check("contend_lat_m1", w1, 32'd3);
`endif
        idle(2);

        // Byte/halfword extension.
        expect_gnt(1, 1'b1, 32'h20); expect_rsp(1, 32'hFFFFFF80, 1'b0);
        issue(1, 1'b0, MemByte, 32'h20, 32'h0, 1'b0, 1'b0, w1);
        expect_gnt(1, 1'b1, 32'h20); expect_rsp(1, 32'h00000080, 1'b0);
        issue(1, 1'b0, MemByte, 32'h20, 32'h0, 1'b1, 1'b0, w1);
        expect_gnt(0, 1'b1, 32'h30); expect_rsp(0, 32'hFFFFA534, 1'b0);
        issue(0, 1'b0, MemHalf, 32'h30, 32'h0, 1'b0, 1'b0, w0);

        // Writes return zero data; merged readback.
        expect_gnt(0, 1'b1, 32'h40); expect_rsp(0, 32'h0, 1'b0);
        issue(0, 1'b1, MemWord, 32'h40, 32'hCAFEF00D, 1'b0, 1'b0, w0);
        expect_gnt(0, 1'b1, 32'h41); expect_rsp(0, 32'h0, 1'b0);
        issue(0, 1'b1, MemByte, 32'h41, 32'h000000AA, 1'b0, 1'b0, w0);
        expect_gnt(1, 1'b1, 32'h40); expect_rsp(1, 32'hCAFEAA0D, 1'b0);
        issue(1, 1'b0, MemWord, 32'h40, 32'h0, 1'b0, 1'b0, w1);
        idle(2);

        // Locked burst of six m1 writes, m0 arrives one cycle later.
        for (int i = 0; i < 4; i++) expect_gnt(1, 1'b1, 32'h100 + 32'(4 * i));
        expect_gnt(0, 1'b1, 32'h10);
        expect_gnt(1, 1'b1, 32'h110);
        expect_gnt(1, 1'b1, 32'h114);
        for (int i = 0; i < 6; i++) expect_rsp(1, 32'h0, 1'b0);
        expect_rsp(0, 32'hDEADBEEF, 1'b0);
        fork
            for (int i = 0; i < 6; i++)
                issue(1, 1'b1, MemWord, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, i < 5, wa_);
            begin
                @(posedge clk);
                #1;
                issue(0, 1'b0, MemWord, 32'h10, 32'h0, 1'b0, 1'b0, wb_);
            end
        join
        expect_gnt(0, 1'b1, 32'h114); expect_rsp(0, 32'hA5, 1'b0);
        issue(0, 1'b0, MemWord, 32'h114, 32'h0, 1'b0, 1'b0, w0);
        idle(2);

        // Misaligned and out-of-range accesses, plus legal accesses at the top boundary.
        expect_gnt(0, 1'b0, 32'h0); expect_rsp(0, 32'h0, 1'b1);
        issue(0, 1'b1, MemHalf, 32'h0003, 32'h0000BEEF, 1'b0, 1'b0, w0);
        expect_gnt(0, 1'b0, 32'h0); expect_rsp(0, 32'h0, 1'b1);
        issue(0, 1'b1, MemWord, 32'hFFFE, 32'h55555555, 1'b0, 1'b0, w0);
        expect_gnt(0, 1'b1, 32'hFFFC); expect_rsp(0, 32'h11223344, 1'b0);
        issue(0, 1'b0, MemWord, 32'hFFFC, 32'h0, 1'b0, 1'b0, w0);
        expect_gnt(0, 1'b1, 32'hFFFF); expect_rsp(0, 32'h00000011, 1'b0);
        issue(0, 1'b0, MemByte, 32'hFFFF, 32'h0, 1'b1, 1'b0, w0);
        expect_gnt(1, 1'b0, 32'h0); expect_rsp(1, 32'h0, 1'b1);
        issue(1, 1'b0, MemByte, 32'h10000, 32'h0, 1'b0, 1'b0, w1);
        expect_gnt(0, 1'b1, 32'h0); expect_rsp(0, 32'h22110000, 1'b0);
        issue(0, 1'b0, MemWord, 32'h0, 32'h0, 1'b0, 1'b0, w0);
        idle(3);
        @(negedge clk);
        check("hold_rd_data_m0", m0_bus.rd_data, 32'h22110000);
        check("hold_err_m1", m1_bus.err, 32'd1);
        idle(1);

        // Reset asserted while GRANT1 is active; m1 keeps requesting and re-arbitrates.
        expect_gnt(1, 1'b1, 32'h20);
        expect_rsp(1, 32'h00000080, 1'b0);
        fork
            issue(1, 1'b0, MemByte, 32'h20, 32'h0, 1'b1, 1'b0, w1);
            begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_mid_gnt", m1_bus.gnt, 32'd0);
                check("rst_mid_dmem_req", dmem_req, 32'd0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_no_rvalid", {m1_bus.rvalid, m1_bus.gnt, m1_bus.err}, 32'd0);
                check("rst_rd_data_m1", m1_bus.rd_data, 32'd0);
                check("rst_rd_data_m0", m0_bus.rd_data, 32'd0);
            end
        join
        check("rst_rearb_lat", w1, 32'd4);

        repeat (4) @(negedge clk);
        check("gnt_queue_left", gq.size(), 32'd0);
        check("rsp_queue_left", rq0.size() + rq1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
